// File: rtl/wb_region_router.sv
// wb_region_router: splits the management Wishbone slave port between the
// user region (default) and an 8-byte debug-register window. The target is
// latched per transaction, the host ack is registered, and a per-transaction
// watchdog forces completion with ERR_DATA if the selected target never acks.
//
// Optional build macro: WB_ROUTER_TIMEOUT_IRQ_EN
//   adds timeout_irq_o (one-cycle pulse per timeout completion) and
//   timeout_clr_i (synchronous clear of timeout_cnt_o, wins over increment).
module wb_region_router #(
  parameter logic [31:0] DBG_BASE = 32'h300FFFF8,
  parameter int unsigned TIMEOUT  = 255,          // 2..1023
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        usr_cyc_o,
  output logic        usr_stb_o,
  input  logic        usr_ack_i,
  input  logic [31:0] usr_dat_i,
  output logic        dbg_cyc_o,
  output logic        dbg_stb_o,
  input  logic        dbg_ack_i,
  input  logic [31:0] dbg_dat_i,
  output logic [7:0]  timeout_cnt_o
`ifdef WB_ROUTER_TIMEOUT_IRQ_EN
  ,
  output logic        timeout_irq_o,
  input  logic        timeout_clr_i
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic       TGT_USR = 1'b0;
  localparam logic       TGT_DBG = 1'b1;
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        tgt_q, tgt_d;
  logic [9:0]  wd_q, wd_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        req, dbg_hit, sel_ack, wd_term, tmo_done;
  logic [31:0] sel_dat;

  // we/sel/adr/dat_i are wired straight from the host bus to both targets at
  // the wrapper level; the router itself only needs the upper address bits.
  logic unused_ok;
  assign unused_ok = ^{wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i[2:0]};

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign dbg_hit  = (wbs_adr_i[31:3] == DBG_BASE[31:3]);
  assign sel_ack  = (tgt_q == TGT_DBG) ? dbg_ack_i : usr_ack_i;
  assign sel_dat  = (tgt_q == TGT_DBG) ? dbg_dat_i : usr_dat_i;
  assign wd_term  = (wd_q == WD_LAST);
  // Ack beats the watchdog when both land in the same cycle.
  assign tmo_done = (state_q == S_WAIT) & wbs_cyc_i & ~sel_ack & wd_term;

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; a host abort takes priority over any ack in WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = S_WAIT;
      S_WAIT: begin
        if (!wbs_cyc_i)             state_d = S_IDLE;
        else if (sel_ack || wd_term) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Slave strobes: only the latched target, only while waiting, and they
  // follow the host cyc/stb combinationally so an abort drops them at once.
  always_comb begin
    usr_cyc_o = 1'b0;
    usr_stb_o = 1'b0;
    dbg_cyc_o = 1'b0;
    dbg_stb_o = 1'b0;
    if (state_q == S_WAIT) begin
      if (tgt_q == TGT_DBG) begin
        dbg_cyc_o = wbs_cyc_i;
        dbg_stb_o = wbs_stb_i;
      end else begin
        usr_cyc_o = wbs_cyc_i;
        usr_stb_o = wbs_stb_i;
      end
    end
  end

  // Datapath next state: target latch, watchdog, response and timeout count.
  always_comb begin
    tgt_d = tgt_q;
    wd_d  = wd_q;
    ack_d = 1'b0;
    dat_d = dat_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          tgt_d = dbg_hit ? TGT_DBG : TGT_USR;
          wd_d  = 10'd0;
        end
      end
      S_WAIT: begin
        if (wbs_cyc_i) begin
          wd_d = wd_q + 10'd1;
          if (sel_ack) begin
            ack_d = 1'b1;
            dat_d = sel_dat;
          end else if (wd_term) begin
            ack_d = 1'b1;
            dat_d = ERR_DATA;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
`ifdef WB_ROUTER_TIMEOUT_IRQ_EN
    if (timeout_clr_i) cnt_d = 8'd0;
`endif
  end

  // Datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      tgt_q <= TGT_USR;
      wd_q  <= 10'd0;
      ack_q <= 1'b0;
      dat_q <= 32'd0;
      cnt_q <= 8'd0;
    end else begin
      tgt_q <= tgt_d;
      wd_q  <= wd_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign timeout_cnt_o = cnt_q;

`ifdef WB_ROUTER_TIMEOUT_IRQ_EN
  logic irq_q;

  // Timeout pulse lands in DONE together with the forced ack.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) irq_q <= 1'b0;
    else            irq_q <= tmo_done;
  end

  assign timeout_irq_o = irq_q;
`else
  logic unused_tmo;
  assign unused_tmo = tmo_done;
`endif

endmodule
